cert_chain_sequencer: RTL and testbench

- Controller for the certificate-answer datapath. On a start pulse it walks the certificate chain of one slot in order and issues one GET_CERTIFICATE request per certificate, with offset = running sum of previous lengths and length taken from an external length ROM.
- It drives the answer block's Enable/Param1/offset/length, waits for Ack_out, and hands each chunk to a downstream packetiser with a valid/ready handshake.
- It aborts on invalid-request, timeout or offset overflow.

---
 rtl/cert_chain_sequencer_if.sv | 28 ++
 rtl/cert_chain_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cert_chain_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cert_chain_sequencer_if.sv
// Request/response bus between the chain sequencer, the certificate answer
// block and the downstream packetiser.
interface cert_chain_sequencer_if #(
  parameter int HDR_W = 8
);
  logic             gc_enable;
  logic [HDR_W-1:0] gc_param1;
  logic [15:0]      gc_offset;
  logic [15:0]      gc_length;
  logic             gc_ack;
  logic             gc_error;
  logic [15:0]      gc_wlength;
  logic             chunk_valid;
  logic             chunk_ready;
  logic [2:0]       chunk_index;

  modport master (
    output gc_enable, gc_param1, gc_offset, gc_length,
    output chunk_valid, chunk_index,
    input  gc_ack, gc_error, gc_wlength, chunk_ready
  );

  modport slave (
    input  gc_enable, gc_param1, gc_offset, gc_length,
    input  chunk_valid, chunk_index,
    output gc_ack, gc_error, gc_wlength, chunk_ready
  );
endinterface

// File: rtl/cert_chain_sequencer.sv
// Walks one slot's certificate chain, issuing one GET_CERTIFICATE request per
// certificate and handing each acknowledged chunk to the packetiser.
module cert_chain_sequencer #(
  parameter int HDR_W       = 8,
  parameter int SLOT0_CERTS = 6,
  parameter int SLOT1_CERTS = 4,
  parameter int SLOT2_CERTS = 5,
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            slot,
  output logic                  busy,
  output logic [2:0]            len_idx,
  input  logic [15:0]           len_value,
  cert_chain_sequencer_if.master bus,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_ISSUE,
    S_WAIT_ACK,
    S_DELIVER,
    S_GAP,
    S_COMPLETE,
    S_FAIL
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    slot_q;
  logic [1:0]    fail_code;
  logic [2:0]    idx;
  logic [15:0]   acc;
  logic [15:0]   offset_q;
  logic [15:0]   length_q;
  logic [TW-1:0] timer;
  logic [3:0]    certs;
  logic          last_cert;
  logic          len_ovf;

  always_comb begin
    case (slot_q)
      2'd0:    certs = 4'(SLOT0_CERTS);
      2'd1:    certs = 4'(SLOT1_CERTS);
      2'd2:    certs = 4'(SLOT2_CERTS);
      default: certs = 4'd0;
    endcase
  end

  assign last_cert = (({1'b0, idx} + 4'd1) == certs);
  // A 17-bit sum catches chains whose total length no longer fits the offset field.
  assign len_ovf   = (({1'b0, acc} + {1'b0, len_value}) > 17'h0FFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fail_code  = 2'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (slot == 2'd3) begin
            state_next = S_FAIL;
            fail_code  = 2'd3;
          end else begin
            state_next = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (len_ovf) begin
          state_next = S_FAIL;
          fail_code  = 2'd3;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT_ACK;
      // An ack arriving on the last allowed cycle takes priority over the timeout.
      S_WAIT_ACK: begin
        if (bus.gc_ack) begin
          if (bus.gc_error || (bus.gc_wlength != length_q)) begin
            state_next = S_FAIL;
            fail_code  = 2'd1;
          end else begin
            state_next = S_DELIVER;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_next = S_FAIL;
          fail_code  = 2'd2;
        end
      end
      S_DELIVER: begin
        if (bus.chunk_ready) state_next = last_cert ? S_COMPLETE : S_GAP;
      end
      S_GAP:      state_next = S_LOOKUP;
      S_COMPLETE: state_next = S_IDLE;
      S_FAIL:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q   <= 2'd0;
      idx      <= 3'd0;
      acc      <= 16'd0;
      offset_q <= 16'd0;
      length_q <= 16'd0;
      timer    <= '0;
      err_code <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            slot_q   <= slot;
            err_code <= 2'd0;
            idx      <= 3'd0;
            acc      <= 16'd0;
          end
        end
        S_LOOKUP: begin
          length_q <= len_value;
          offset_q <= acc;
          timer    <= '0;
        end
        S_ISSUE, S_WAIT_ACK: timer <= timer + 1'b1;
        S_DELIVER: begin
          if (bus.chunk_ready) begin
            acc <= acc + length_q;
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
      if (fail_code != 2'd0) err_code <= fail_code;
    end
  end

  always_comb begin
    busy            = (state != S_IDLE);
    bus.gc_enable   = (state == S_ISSUE) || (state == S_WAIT_ACK) || (state == S_DELIVER);
    bus.chunk_valid = (state == S_DELIVER);
    bus.chunk_index = idx;
    bus.gc_param1   = HDR_W'(slot_q);
    bus.gc_offset   = offset_q;
    bus.gc_length   = length_q;
    len_idx         = idx;
    done            = (state == S_COMPLETE);
    error           = (state == S_FAIL);
  end

endmodule

// File: tb/tb_cert_chain_sequencer.sv
// Directed bench for cert_chain_sequencer: a behavioural answer block, length
// ROM and packetiser surround the DUT; each task checks one scenario.
module tb_cert_chain_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  slot;
  logic        busy;
  logic [2:0]  len_idx;
  logic [15:0] len_value;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  cert_chain_sequencer_if #(.HDR_W(8)) bus ();

  cert_chain_sequencer #(
    .HDR_W(8), .SLOT0_CERTS(6), .SLOT1_CERTS(4), .SLOT2_CERTS(5), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .slot(slot), .busy(busy),
    .len_idx(len_idx), .len_value(len_value), .bus(bus.master),
    .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:7];
  assign len_value = rom[len_idx];

  // Scenario controls, written only by the main sequence.
  bit          no_ack_all;
  int          no_ack_at;
  int          err_at;
  int          stall_at;
  int          stall_len;
  int          stall_base;
  logic [15:0] stall_off;

  // Observation log, written only by the responder.
  int          cyc = 0;
  int          req_n = 0;
  int          hs_n = 0;
  int          done_n = 0;
  int          err_n = 0;
  int          en_cyc = 0;
  int          err_cyc = 0;
  int          stall_cnt = 0;
  int          stall_glitch = 0;
  int          valid_at_err = 0;
  logic        en_prev = 1'b0;
  logic [15:0] req_off [0:63];
  logic [15:0] req_len [0:63];
  logic [7:0]  req_p1  [0:63];
  logic [2:0]  hs_idx  [0:63];

  // Answer block and packetiser model: drives inputs on the falling edge,
  // logs requests, handshakes and pulses seen by the DUT.
  initial begin
    bus.gc_ack      = 1'b0;
    bus.gc_error    = 1'b0;
    bus.gc_wlength  = 16'd0;
    bus.chunk_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.gc_enable && !en_prev) begin
        if (req_n < 64) begin
          req_off[req_n] = bus.gc_offset;
          req_len[req_n] = bus.gc_length;
          req_p1[req_n]  = bus.gc_param1;
        end
        req_n++;
        en_cyc = cyc;
      end
      en_prev = bus.gc_enable;
      if (done) done_n++;
      if (error) begin
        err_n++;
        err_cyc = cyc;
      end
      bus.gc_ack     = bus.gc_enable && !no_ack_all && (int'(bus.chunk_index) != no_ack_at);
      bus.gc_error   = bus.gc_enable && (int'(bus.chunk_index) == err_at);
      bus.gc_wlength = bus.gc_length;
      if (bus.chunk_valid && int'(bus.chunk_index) == stall_at &&
          (stall_cnt - stall_base) < stall_len) begin
        bus.chunk_ready = 1'b0;
        stall_cnt++;
        if (!bus.gc_enable || bus.gc_offset != stall_off) stall_glitch++;
      end else begin
        bus.chunk_ready = 1'b1;
      end
      if (bus.chunk_valid && int'(bus.chunk_index) == err_at) valid_at_err++;
      if (bus.chunk_valid && bus.chunk_ready) begin
        if (hs_n < 64) hs_idx[hs_n] = bus.chunk_index;
        hs_n++;
      end
    end
  end

  task automatic load_rom(input logic [15:0] a, b, c, d, e, f);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d; rom[4] = e; rom[5] = f;
    rom[6] = 16'd0; rom[7] = 16'd0;
  endtask

  task automatic start_chain(input logic [1:0] s);
    @(negedge clk); #1;
    start = 1'b1;
    slot  = s;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(output bit ended);
    ended = 1'b0;
    for (int i = 0; i < 1000 && !ended; i++) begin
      @(negedge clk); #1;
      if (done || error) ended = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [52:0] outs;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    outs = {busy, bus.gc_enable, bus.chunk_valid, done, error, err_code, len_idx,
            bus.chunk_index, bus.gc_param1, bus.gc_offset, bus.gc_length};
    total++;
    if (outs !== 53'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_slot0_chain;
    logic [15:0] exp_off [0:5];
    bit ended;
    int b_req = req_n, b_hs = hs_n, b_done = done_n, b_err = err_n;
    exp_off = '{16'd0, 16'd100, 16'd300, 16'd600, 16'd650, 16'd710};
    load_rom(16'd100, 16'd200, 16'd300, 16'd50, 16'd60, 16'd70);
    start_chain(2'd0);
    wait_end(ended);
    total++;
    if (!ended || !done) begin
      bad++;
      $display("[TB] FAIL slot0_done: got ended=%0d done=%0d expected 1 1", ended, done);
    end
    total++;
    if (err_code !== 2'd0) begin
      bad++;
      $display("[TB] FAIL slot0_err_code: got %0d expected 0", err_code);
    end
    @(negedge clk); #1;
    total++;
    if (done_n - b_done != 1 || err_n - b_err != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL slot0_pulses: got done=%0d err=%0d busy=%0d expected 1 0 0",
               done_n - b_done, err_n - b_err, busy);
    end
    total++;
    if (req_n - b_req != 6 || hs_n - b_hs != 6) begin
      bad++;
      $display("[TB] FAIL slot0_counts: got req=%0d hs=%0d expected 6 6", req_n - b_req, hs_n - b_hs);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (req_off[b_req+i] !== exp_off[i] || req_len[b_req+i] !== rom[i] ||
          hs_idx[b_hs+i] !== 3'(i) || req_p1[b_req+i] !== 8'd0) begin
        bad++;
        $display("[TB] FAIL slot0_req%0d: got off=%0d len=%0d idx=%0d p1=%0d expected %0d %0d %0d 0",
                 i, req_off[b_req+i], req_len[b_req+i], hs_idx[b_hs+i], req_p1[b_req+i],
                 exp_off[i], rom[i], i);
      end
    end
  endtask

  task automatic test_stall;
    logic [15:0] exp_off [0:3];
    bit ended;
    int b_req = req_n, b_hs = hs_n, b_done = done_n, b_glitch = stall_glitch;
    exp_off = '{16'd0, 16'd10, 16'd30, 16'd60};
    load_rom(16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0);
    stall_base = stall_cnt;
    stall_off  = 16'd30;
    stall_len  = 10;
    stall_at   = 2;
    start_chain(2'd1);
    wait_end(ended);
    stall_at  = -1;
    stall_len = 0;
    @(negedge clk); #1;
    total++;
    if (!ended || done_n - b_done != 1) begin
      bad++;
      $display("[TB] FAIL stall_done: got ended=%0d done=%0d expected 1 1", ended, done_n - b_done);
    end
    total++;
    if (stall_cnt - stall_base != 10 || stall_glitch - b_glitch != 0) begin
      bad++;
      $display("[TB] FAIL stall_hold: got cycles=%0d glitches=%0d expected 10 0",
               stall_cnt - stall_base, stall_glitch - b_glitch);
    end
    total++;
    if (req_n - b_req != 4 || hs_n - b_hs != 4) begin
      bad++;
      $display("[TB] FAIL stall_counts: got req=%0d hs=%0d expected 4 4", req_n - b_req, hs_n - b_hs);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (req_off[b_req+i] !== exp_off[i] || req_p1[b_req+i] !== 8'd1) begin
        bad++;
        $display("[TB] FAIL stall_req%0d: got off=%0d p1=%0d expected %0d 1",
                 i, req_off[b_req+i], req_p1[b_req+i], exp_off[i]);
      end
    end
  endtask

  task automatic test_gc_error;
    bit ended;
    int b_req = req_n, b_hs = hs_n, b_done = done_n, b_err = err_n, b_val = valid_at_err;
    load_rom(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0);
    err_at = 3;
    start_chain(2'd2);
    wait_end(ended);
    total++;
    if (!ended || error !== 1'b1 || err_code !== 2'd1) begin
      bad++;
      $display("[TB] FAIL gcerr_pulse: got ended=%0d error=%0d code=%0d expected 1 1 1",
               ended, error, err_code);
    end
    @(negedge clk); #1;
    err_at = -1;
    total++;
    if (busy !== 1'b0 || error !== 1'b0 || err_code !== 2'd1) begin
      bad++;
      $display("[TB] FAIL gcerr_after: got busy=%0d error=%0d code=%0d expected 0 0 1",
               busy, error, err_code);
    end
    total++;
    if (hs_n - b_hs != 3 || req_n - b_req != 4 || valid_at_err - b_val != 0) begin
      bad++;
      $display("[TB] FAIL gcerr_chunks: got hs=%0d req=%0d valid3=%0d expected 3 4 0",
               hs_n - b_hs, req_n - b_req, valid_at_err - b_val);
    end
    total++;
    if (req_p1[b_req] !== 8'd2 || done_n - b_done != 0 || err_n - b_err != 1) begin
      bad++;
      $display("[TB] FAIL gcerr_misc: got p1=%0d done=%0d err=%0d expected 2 0 1",
               req_p1[b_req], done_n - b_done, err_n - b_err);
    end
  endtask

  task automatic test_timeout;
    bit ended;
    int b_req = req_n;
    load_rom(16'd100, 16'd200, 16'd300, 16'd50, 16'd60, 16'd70);
    no_ack_all = 1'b1;
    start_chain(2'd0);
    wait_end(ended);
    total++;
    if (!ended || error !== 1'b1 || err_code !== 2'd2 || bus.gc_enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_pulse: got ended=%0d error=%0d code=%0d en=%0d expected 1 1 2 0",
               ended, error, err_code, bus.gc_enable);
    end
    total++;
    if (err_cyc - en_cyc != 16 || req_n - b_req != 1) begin
      bad++;
      $display("[TB] FAIL timeout_latency: got cycles=%0d req=%0d expected 16 1",
               err_cyc - en_cyc, req_n - b_req);
    end
    no_ack_all = 1'b0;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_idle: got busy=%0d expected 0", busy);
    end
  endtask

  task automatic test_bad_slot;
    int b_req = req_n, b_err = err_n;
    start_chain(2'd3);
    total++;
    if (error !== 1'b1 || err_code !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL badslot_pulse: got error=%0d code=%0d busy=%0d expected 1 3 1",
               error, err_code, busy);
    end
    @(negedge clk); #1;
    total++;
    if (error !== 1'b0 || err_code !== 2'd3 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL badslot_hold: got error=%0d code=%0d busy=%0d expected 0 3 0",
               error, err_code, busy);
    end
    total++;
    if (req_n - b_req != 0 || err_n - b_err != 1) begin
      bad++;
      $display("[TB] FAIL badslot_noreq: got req=%0d err=%0d expected 0 1", req_n - b_req, err_n - b_err);
    end
  endtask

  task automatic test_overflow;
    bit ended;
    int b_req = req_n, b_hs = hs_n, b_done = done_n;
    load_rom(16'hFF00, 16'h0200, 16'd1, 16'd1, 16'd1, 16'd1);
    start_chain(2'd0);
    wait_end(ended);
    total++;
    if (!ended || error !== 1'b1 || err_code !== 2'd3) begin
      bad++;
      $display("[TB] FAIL ovf_pulse: got ended=%0d error=%0d code=%0d expected 1 1 3",
               ended, error, err_code);
    end
    @(negedge clk); #1;
    total++;
    if (req_n - b_req != 1 || hs_n - b_hs != 1 || done_n - b_done != 0 ||
        req_len[b_req] !== 16'hFF00) begin
      bad++;
      $display("[TB] FAIL ovf_progress: got req=%0d hs=%0d done=%0d len=%h expected 1 1 0 ff00",
               req_n - b_req, hs_n - b_hs, done_n - b_done, req_len[b_req]);
    end
  endtask

  task automatic test_reset_mid;
    logic [52:0] outs;
    bit ended;
    bit reached = 1'b0;
    int b_req = req_n, b_done = done_n, b_err = err_n;
    load_rom(16'd100, 16'd200, 16'd300, 16'd50, 16'd60, 16'd70);
    no_ack_at = 1;
    start_chain(2'd0);
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk); #1;
      if (req_n - b_req == 2) reached = 1'b1;
    end
    total++;
    if (!reached) begin
      bad++;
      $display("[TB] FAIL rmid_reach: got requests=%0d expected 2", req_n - b_req);
    end
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    outs = {busy, bus.gc_enable, bus.chunk_valid, done, error, err_code, len_idx,
            bus.chunk_index, bus.gc_param1, bus.gc_offset, bus.gc_length};
    total++;
    if (outs !== 53'd0) begin
      bad++;
      $display("[TB] FAIL rmid_async: got %h expected 0", outs);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    no_ack_at = -1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (done_n - b_done != 0 || err_n - b_err != 0) begin
      bad++;
      $display("[TB] FAIL rmid_nopulse: got done=%0d err=%0d expected 0 0",
               done_n - b_done, err_n - b_err);
    end
    b_req = req_n;
    start_chain(2'd0);
    wait_end(ended);
    total++;
    if (!ended || !done || req_off[b_req] !== 16'd0 || req_off[b_req+1] !== 16'd100) begin
      bad++;
      $display("[TB] FAIL rmid_restart: got ended=%0d done=%0d off0=%0d off1=%0d expected 1 1 0 100",
               ended, done, req_off[b_req], req_off[b_req+1]);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    slot       = 2'd0;
    no_ack_all = 1'b0;
    no_ack_at  = -1;
    err_at     = -1;
    stall_at   = -1;
    stall_len  = 0;
    stall_base = 0;
    stall_off  = 16'd0;
    load_rom(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    test_reset;
    test_slot0_chain;
    test_stall;
    test_gc_error;
    test_timeout;
    test_bad_slot;
    test_overflow;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
